// File: rtl/uart_alu_sequencer_if.sv
// rtl/uart_alu_sequencer_if.sv - FIFO and ALU signal bundle for the UART ALU sequencer
interface uart_alu_sequencer_if #(
  parameter int DBIT = 8,
  parameter int OPW  = 6
);
  logic            rx_empty;
  logic [DBIT-1:0] rx_data;
  logic            rd_uart;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [DBIT-1:0] alu_a;
  logic [DBIT-1:0] alu_b;
  logic [OPW-1:0]  alu_op;
  logic [DBIT-1:0] alu_result;

  modport master (
    input  rx_empty, rx_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );

  modport slave (
    output rx_empty, rx_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A, B, opcode bytes from the rx FIFO and pushes the ALU result
module uart_alu_sequencer #(
  parameter int DBIT = 8,
  parameter int OPW  = 6,
  parameter int TMO  = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_alu_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int            CW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rd_block;
  logic [DBIT-1:0] a_q;
  logic [DBIT-1:0] b_q;
  logic [OPW-1:0]  op_q;
  logic [DBIT-1:0] result;
  logic            waiting_byte;
  logic            rx_take;
  logic            tx_put;
  logic            tmo_hit;

  // Strobes are qualified by reset so they drop the moment reset asserts.
  always_comb begin
    waiting_byte = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
    rx_take      = reset && waiting_byte && !bus.rx_empty && !rd_block;
    tx_put       = reset && (state == SEND) && !bus.tx_full;
    tmo_hit      = reset && ((state == WAIT_B) || (state == WAIT_OP)) &&
                   bus.rx_empty && (cnt == CNT_LAST);
  end

  // rd_block spaces pops apart and also suppresses a pop in the cycle reset releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_A;
      cnt      <= '0;
      rd_block <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result   <= '0;
    end else begin
      rd_block <= rx_take;
      case (state)
        WAIT_A: begin
          if (rx_take) begin
            a_q   <= bus.rx_data;
            state <= WAIT_B;
            cnt   <= '0;
          end
        end
        WAIT_B: begin
          if (rx_take) begin
            b_q   <= bus.rx_data;
            state <= WAIT_OP;
            cnt   <= '0;
          end else if (tmo_hit) begin
            state <= WAIT_A;
            cnt   <= '0;
          end else if (bus.rx_empty) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_OP: begin
          if (rx_take) begin
            op_q  <= bus.rx_data[OPW-1:0];
            state <= EXEC;
            cnt   <= '0;
          end else if (tmo_hit) begin
            state <= WAIT_A;
            cnt   <= '0;
          end else if (bus.rx_empty) begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          result <= bus.alu_result;
          state  <= SEND;
          cnt    <= '0;
        end
        SEND: begin
          if (tx_put) begin
            state <= WAIT_A;
            cnt   <= '0;
          end
        end
        default: begin
          state <= WAIT_A;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rd_uart = rx_take;
  assign bus.wr_uart = tx_put;
  assign bus.w_data  = result;
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_op  = op_q;
  assign busy        = reset && (state != WAIT_A);
  assign timeout_err = tmo_hit;
endmodule
